// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter. Each master holds the grant for one whole CYC,
// responses go back to the owner only, and a strobe watchdog ends hung transfers with ERR.
module wb_arbiter #(
    parameter int aw  = 16,
    parameter int dw  = 32,
    parameter int nm  = 4,
    parameter int tmo = 255
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [nm-1:0]    m_cyc_i,
    input  logic [nm-1:0]    m_stb_i,
    input  logic [nm-1:0]    m_we_i,
    input  logic [nm*aw-1:0] m_adr_i,
    input  logic [nm*dw-1:0] m_dat_i,
    input  logic [nm*4-1:0]  m_sel_i,
    input  logic [nm*4-1:0]  m_tag_i,
    output logic [nm-1:0]    m_ack_o,
    output logic [nm-1:0]    m_err_o,
    output logic [nm-1:0]    m_rty_o,
    output logic [dw-1:0]    m_dat_o,
    output logic [3:0]       m_tag_o,
    output logic             CYC_O,
    output logic             STB_O,
    output logic             WE_O,
    output logic [aw-1:0]    ADR_O,
    output logic [dw-1:0]    DAT_O,
    output logic [3:0]       SEL_O,
    output logic [3:0]       TAG_O,
    input  logic             ACK_I,
    input  logic             ERR_I,
    input  logic             RTY_I,
    input  logic [dw-1:0]    DAT_I,
    input  logic [3:0]       TAG_I,
    output logic [nm-1:0]    gnt_o
);

    localparam int              LW    = $clog2(nm);
    localparam int              WW    = (tmo > 0) ? $clog2(tmo + 1) : 1;
    localparam logic [LW:0]     NM_W  = (LW + 1)'(nm);
    localparam logic [WW-1:0]   TMO_W = WW'(tmo);
    localparam bit              WD_EN = (tmo != 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [nm-1:0] gnt_q, gnt_d;
    logic [LW-1:0] last_q, last_d;
    logic [WW-1:0] wdog_q, wdog_d;

    logic [LW-1:0] ownerIdx;
    logic          ownerCyc;
    logic          ownerStb;
    logic          ownerWe;
    logic [aw-1:0] ownerAdr;
    logic [dw-1:0] ownerDat;
    logic [3:0]    ownerSel;
    logic [3:0]    ownerTag;
    logic          anyResp;
    logic          wdFire;
    logic [LW:0]   cand;
    logic          found;

    // The grant vector is one-hot or zero, so an OR-style mux leaves every field 0 with no owner.
    always_comb begin
        ownerIdx = '0;
        ownerCyc = 1'b0;
        ownerStb = 1'b0;
        ownerWe  = 1'b0;
        ownerAdr = '0;
        ownerDat = '0;
        ownerSel = '0;
        ownerTag = '0;
        for (int k = 0; k < nm; k++) begin
            if (gnt_q[k]) begin
                ownerIdx = LW'(k);
                ownerCyc = m_cyc_i[k];
                ownerStb = m_stb_i[k];
                ownerWe  = m_we_i[k];
                ownerAdr = m_adr_i[k*aw +: aw];
                ownerDat = m_dat_i[k*dw +: dw];
                ownerSel = m_sel_i[k*4 +: 4];
                ownerTag = m_tag_i[k*4 +: 4];
            end
        end
    end

    // A real slave response in the limit cycle takes precedence over the watchdog.
    assign anyResp = ACK_I | ERR_I | RTY_I;
    assign wdFire  = WD_EN && (wdog_q == TMO_W) && !anyResp;

    assign gnt_o   = gnt_q;
    assign CYC_O   = ownerCyc;
    assign STB_O   = ownerStb & ~wdFire;
    assign WE_O    = ownerWe;
    assign ADR_O   = ownerAdr;
    assign DAT_O   = ownerDat;
    assign SEL_O   = ownerSel;
    assign TAG_O   = ownerTag;

    assign m_ack_o = gnt_q & {nm{ACK_I}};
    assign m_err_o = gnt_q & {nm{ERR_I | wdFire}};
    assign m_rty_o = gnt_q & {nm{RTY_I}};
    assign m_dat_o = DAT_I;
    assign m_tag_o = TAG_I;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cand    = '0;
        found   = 1'b0;
        case (state_q)
            IDLE: begin
                // Scan last+1, last+2, ... wrapping at nm; the first requester wins.
                for (int i = 1; i <= nm; i++) begin
                    cand = {1'b0, last_q} + (LW + 1)'(i);
                    if (cand >= NM_W) begin
                        cand = cand - NM_W;
                    end
                    if (!found && m_cyc_i[cand[LW-1:0]]) begin
                        found                = 1'b1;
                        gnt_d                = '0;
                        gnt_d[cand[LW-1:0]]  = 1'b1;
                    end
                end
                if (found) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!ownerCyc) begin
                    gnt_d   = '0;
                    last_d  = ownerIdx;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counts strobe cycles without a response and saturates at the limit.
    always_comb begin
        wdog_d = wdog_q;
        if ((state_q != BUSY) || !ownerCyc || !STB_O || anyResp) begin
            wdog_d = '0;
        end else if (WD_EN && (wdog_q != TMO_W)) begin
            wdog_d = wdog_q + WW'(1);
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= LW'(nm - 1);
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Round-robin Wishbone bus arbiter that lets up to nm bus masters share one Wishbone slave port, such as the prefetch SPRAM.
- Grants ownership per bus cycle (CYC), muxes the owner's signals to the slave, and routes ACK/ERR/RTY back to the owner only.
- Includes a bus-timeout watchdog that terminates a hung strobe with ERR.
- Sits between the behavioural/RTL masters and the shared slave in the bench and SoC top.

Parameters:
- aw, 16, address width
- dw, 32, data width
- nm, 4, number of masters (2..8)
- tmo, 255, watchdog limit in cycles of unacknowledged STB; 0 disables the watchdog

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  reset; asynchronous, active-high
- m_cyc_i  in  nm  per-master CYC
- m_stb_i  in  nm  per-master STB
- m_we_i  in  nm  per-master WE
- m_adr_i  in  nm*aw  per-master address; master k occupies bits [k*aw +: aw]
- m_dat_i  in  nm*dw  per-master write data
- m_sel_i  in  nm*4  per-master byte selects
- m_tag_i  in  nm*4  per-master TAG
- m_ack_o  out  nm  ACK, owner only
- m_err_o  out  nm  ERR, owner only; includes watchdog ERR
- m_rty_o  out  nm  RTY, owner only
- m_dat_o  out  dw  read data, DAT_I broadcast to all masters
- m_tag_o  out  4  TAG_I broadcast to all masters
- CYC_O, STB_O, WE_O  out  1 each  to slave
- ADR_O  out  aw  to slave
- DAT_O  out  dw  to slave
- SEL_O  out  4  to slave
- TAG_O  out  4  to slave
- ACK_I, ERR_I, RTY_I  in  1 each  from slave
- DAT_I  in  dw  from slave
- TAG_I  in  4  from slave
- gnt_o  out  nm  one-hot current owner (registered)

Behaviour:
- Reset (async, RST_I=1):
  - state=IDLE, gnt_o=0, wdog=0, last=nm-1, so master 0 has first priority.
  - All slave-side outputs and m_ack_o/m_err_o/m_rty_o are 0 immediately.
  - Reset mid-transfer aborts the cycle with no ACK to the master.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any m_cyc_i is set, the next edge grants the first requester scanning last+1, last+2, ... modulo nm, then state=BUSY.
  - CYC_O asserts one cycle after the master's CYC is first sampled.
- BUSY:
  - Grant is held while the owner's m_cyc_i=1. Other masters' requests are ignored and their ack/err/rty stay 0.
  - Owner drops m_cyc_i: at that edge gnt_o=0, last=owner index, state=IDLE.
  - There is exactly one dead cycle between owners. Back-to-back requests from a different master are granted at the following edge.
- Muxing (combinational from gnt_o):
  - CYC_O = owner m_cyc_i.
  - STB_O = owner m_stb_i & ~wd_fire.
  - WE_O, ADR_O, DAT_O, SEL_O, TAG_O come from the owner slice.
  - All slave outputs are 0 when gnt_o=0.
- Response routing: m_ack_o[k] = gnt_o[k] & ACK_I; likewise for RTY. m_err_o[k] = gnt_o[k] & (ERR_I | wd_fire).
- Block/RMW cycles: ownership spans all strobes of one CYC. STB may drop between beats without losing the grant.
- Watchdog:
  - wdog increments each cycle STB_O=1 & ~(ACK_I|ERR_I|RTY_I).
  - Clears on any response, on STB_O=0, or on leaving BUSY.
  - wd_fire = (tmo!=0) & (wdog==tmo).
  - Fire cycle: STB_O is forced 0, owner sees ERR for exactly 1 cycle, wdog clears next edge.
  - The grant is kept until the owner drops CYC.
- Width rules: wdog is clog2(tmo+1) bits and saturates at tmo; no wrap.
- Simultaneous events:
  - Slave response on the same cycle as wd_fire: the response wins, no fire.
  - Owner drops CYC on the same cycle as ACK: ACK is still routed, and the FSM returns to IDLE at that edge.
- Index wrap: the search after last=nm-1 starts at 0.

Test Plan:
- Reset, then master 0 single read of addr 0x0010, slave ACK with DAT_I=0xDEADBEEF after 2 cycles -> gnt_o=0001 one cycle after m_cyc_i; ADR_O=0x0010; m_ack_o=0001 for 1 cycle; m_dat_o=0xDEADBEEF; FSM returns to IDLE.
- Masters 0, 1, 2 request simultaneously, each issuing one write -> grant order 0,1,2 with one dead cycle between owners; next simultaneous round starts at master 3 if it requests, otherwise at 0.
- Master 1 does a 4-beat block write (CYC held, STB pulsed) while master 2 requests -> master 2 granted only after master 1 drops CYC; m_ack_o[2] stays 0 throughout.
- tmo=8, owner strobes and slave never responds -> STB_O high 8 cycles, then wd_fire: STB_O=0, m_err_o[owner]=1 for exactly 1 cycle; tmo=0 run never fires.
- RST_I pulsed asynchronously mid-BUSY with STB_O=1 -> CYC_O, STB_O, gnt_o go 0 without a clock edge; the first grant after release goes to master 0.
- Slave RTY_I and ERR_I each pulsed to owner -> only the owner's m_rty_o/m_err_o bit asserts; wdog clears.
